// File: rtl/rf_scoreboard_pkg.sv
// Shared core definitions for the register-file write scoreboard.
//   SB_REG_COUNT : number of architectural registers tracked
//   SB_PTR_W     : width of a register pointer
//   SB_CNT_W     : width of each per-register in-flight counter
//   SB_CNT_MAX   : saturation value of a counter (2^SB_CNT_W - 1)
package rf_scoreboard_pkg;
  localparam int SB_REG_COUNT = 16;
  localparam int SB_PTR_W     = 4;
  localparam int SB_CNT_W     = 2;
  localparam int SB_CNT_MAX   = (1 << SB_CNT_W) - 1;
  localparam int SB_TOTAL_W   = 6;
endpackage

// File: rtl/rf_scoreboard_if.sv
// Issue / writeback / status bundle between the FD/MW pipeline and the
// scoreboard.
//   master : pipeline side, drives flush, issue_* and wb_* requests
//   slave  : scoreboard side, returns issue_accept, stall, busy_mask,
//            inflight_total and sb_error
interface rf_scoreboard_if
  import rf_scoreboard_pkg::*;
#(
  parameter int REG_COUNT = SB_REG_COUNT
);
  logic                  flush;
  logic                  issue_valid;
  logic                  issue_writes;
  logic [SB_PTR_W-1:0]   issue_dst;
  logic [SB_PTR_W-1:0]   issue_src_0;
  logic [SB_PTR_W-1:0]   issue_src_1;
  logic [SB_PTR_W-1:0]   issue_src_2;
  logic [2:0]            issue_src_used;
  logic                  wb_valid;
  logic [SB_PTR_W-1:0]   wb_dst;
  logic                  issue_accept;
  logic                  stall;
  logic [REG_COUNT-1:0]  busy_mask;
  logic [SB_TOTAL_W-1:0] inflight_total;
  logic                  sb_error;

  modport master (
    output flush, issue_valid, issue_writes, issue_dst,
           issue_src_0, issue_src_1, issue_src_2, issue_src_used,
           wb_valid, wb_dst,
    input  issue_accept, stall, busy_mask, inflight_total, sb_error
  );

  modport slave (
    input  flush, issue_valid, issue_writes, issue_dst,
           issue_src_0, issue_src_1, issue_src_2, issue_src_used,
           wb_valid, wb_dst,
    output issue_accept, stall, busy_mask, inflight_total, sb_error
  );
endinterface

// File: rtl/rf_scoreboard_sb_counter.sv
// One in-flight write counter for a single architectural register.
//   clk, reset_n : clock and asynchronous active-low reset
//   inc, dec     : one pending write issued / retired this cycle
//   flush        : clear the counter, overriding inc/dec
//   count        : current number of writes in flight
//   nonzero      : count != 0
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output logic             nonzero
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (inc && !dec) begin
      // Issue is stalled at max, so this guard only protects against misuse.
      if (count != CNT_MAX) count <= count + CNT_W'(1);
    end else if (dec && !inc) begin
      count <= count - CNT_W'(1);
    end
  end

  assign nonzero = |count;
endmodule

// File: rtl/rf_scoreboard.sv
// Register-file write scoreboard. Tracks writes in flight per register,
// stalls FD on RAW hazards and on counter saturation (WAW depth), and flags
// writebacks to registers with nothing pending.
//   clk, reset_n : clock and asynchronous active-low reset
//   sb (slave)   : issue/writeback requests in, accept/stall/status out
module rf_scoreboard
  import rf_scoreboard_pkg::*;
#(
  parameter int REG_COUNT = SB_REG_COUNT,
  parameter int CNT_W     = SB_CNT_W
) (
  input logic            clk,
  input logic            reset_n,
  rf_scoreboard_if.slave sb
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0]    cnt [REG_COUNT];
  logic [REG_COUNT-1:0] nz;
  logic [REG_COUNT-1:0] inc_v;
  logic [REG_COUNT-1:0] dec_v;
  logic [SB_PTR_W-1:0] src [3];
  logic [2:0]          hit;
  logic                stall_c;
  logic                accept_c;
  logic                underflow;
  logic                sb_error_q;
  logic [SB_TOTAL_W-1:0] total_c;

  assign src[0] = sb.issue_src_0;
  assign src[1] = sb.issue_src_1;
  assign src[2] = sb.issue_src_2;

  // A source whose only pending write is retiring this cycle is served by
  // the RF write-through bypass, so it is not a hazard.
  always_comb begin
    hit = '0;
    for (int k = 0; k < 3; k++) begin
      hit[k] = sb.issue_src_used[k] & nz[src[k]]
             & ~(sb.wb_valid & (sb.wb_dst == src[k]) & (cnt[src[k]] == CNT_ONE));
    end
  end

  assign stall_c  = sb.issue_valid
                  & ((|hit) | (sb.issue_writes & (cnt[sb.issue_dst] == CNT_MAX)));
  assign accept_c = sb.issue_valid & ~stall_c;

  always_comb begin
    inc_v = '0;
    dec_v = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      inc_v[i] = accept_c & sb.issue_writes & (sb.issue_dst == SB_PTR_W'(i));
      dec_v[i] = sb.wb_valid & (sb.wb_dst == SB_PTR_W'(i)) & nz[i];
    end
  end

  for (genvar g = 0; g < REG_COUNT; g++) begin : g_cnt
    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (inc_v[g]),
      .dec     (dec_v[g]),
      .flush   (sb.flush),
      .count   (cnt[g]),
      .nonzero (nz[g])
    );
  end

  assign underflow = sb.wb_valid & ~nz[sb.wb_dst];

  // Sticky until reset; flush deliberately leaves it alone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       sb_error_q <= 1'b0;
    else if (underflow) sb_error_q <= 1'b1;
  end

  always_comb begin
    total_c = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      total_c = total_c + SB_TOTAL_W'(cnt[i]);
    end
  end

  assign sb.stall          = stall_c;
  assign sb.issue_accept   = accept_c;
  assign sb.busy_mask      = nz;
  assign sb.inflight_total = total_c;
  assign sb.sb_error       = sb_error_q;
endmodule

// File: tb/tb_rf_scoreboard.sv
module tb_rf_scoreboard;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  rf_scoreboard_if #(.REG_COUNT(16)) sbi ();

  rf_scoreboard #(.REG_COUNT(16), .CNT_W(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .sb      (sbi)
  );

  typedef struct {
    logic        stall;
    logic        accept;
    logic [15:0] busy;
    logic [5:0]  total;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: number of outstanding writes per register, sticky error.
  int   pend [16];
  bit   m_err;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) pend[i] = 0;
    m_err = 0;
  endtask

  function automatic bit src_blocks(input int r, input bit wv, input int wd);
    // Blocked if anything is pending, unless the last pending write lands now.
    return (pend[r] != 0) && !(wv && wd == r && pend[r] == 1);
  endfunction

  // Drive one cycle of stimulus, push expected response, advance the model.
  task automatic apply(input bit fl, input bit iv, input bit iw, input int d,
                       input int s0, input int s1, input int s2, input bit [2:0] used,
                       input bit wv, input int wd);
    exp_t e;
    bit   blk;
    bit   retire;
    int   tot;
    @(negedge clk);
    sbi.flush          = fl;
    sbi.issue_valid    = iv;
    sbi.issue_writes   = iw;
    sbi.issue_dst      = 4'(d);
    sbi.issue_src_0    = 4'(s0);
    sbi.issue_src_1    = 4'(s1);
    sbi.issue_src_2    = 4'(s2);
    sbi.issue_src_used = used;
    sbi.wb_valid       = wv;
    sbi.wb_dst         = 4'(wd);

    blk = (used[0] && src_blocks(s0, wv, wd)) || (used[1] && src_blocks(s1, wv, wd)) ||
          (used[2] && src_blocks(s2, wv, wd)) || (iw && pend[d] == 3);
    e.stall  = iv && blk;
    e.accept = iv && !blk;
    tot = 0;
    for (int i = 0; i < 16; i++) begin
      e.busy[i] = (pend[i] != 0);
      tot += pend[i];
    end
    e.total = 6'(tot);
    e.err   = m_err;
    q.push_back(e);

    retire = wv && pend[wd] != 0;
    if (wv && pend[wd] == 0) m_err = 1;
    if (fl) begin
      for (int i = 0; i < 16; i++) pend[i] = 0;
    end else begin
      if (e.accept && iw) pend[d]++;
      if (retire) pend[wd]--;
    end
  endtask

  task automatic idle();
    apply(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0);
  endtask

  // Monitor: compares the DUT's combinational response mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("stall",          int'(sbi.stall),          int'(e.stall));
        chk("issue_accept",   int'(sbi.issue_accept),   int'(e.accept));
        chk("busy_mask",      int'(sbi.busy_mask),      int'(e.busy));
        chk("inflight_total", int'(sbi.inflight_total), int'(e.total));
        chk("sb_error",       int'(sbi.sb_error),       int'(e.err));
      end
    end
  end

  task automatic drain();
    int budget = 20;
    while (q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    #3;
    if (q.size() > 0) chk("drain_timeout", q.size(), 0);
  endtask

  initial begin
    sbi.flush = 0; sbi.issue_valid = 0; sbi.issue_writes = 0; sbi.issue_dst = 0;
    sbi.issue_src_0 = 0; sbi.issue_src_1 = 0; sbi.issue_src_2 = 0;
    sbi.issue_src_used = 0; sbi.wb_valid = 0; sbi.wb_dst = 0;
    model_reset();
    #12;
    chk("rst_busy_mask",      int'(sbi.busy_mask), 0);
    chk("rst_inflight_total", int'(sbi.inflight_total), 0);
    chk("rst_sb_error",       int'(sbi.sb_error), 0);
    chk("rst_stall",          int'(sbi.stall), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // RAW: write R3, dependent read stalls until the writeback cycle.
    apply(0, 1, 1, 3, 0, 0, 0, 3'b000, 0, 0);
    apply(0, 1, 0, 0, 3, 0, 0, 3'b001, 0, 0);
    apply(0, 1, 0, 0, 3, 0, 0, 3'b001, 0, 0);
    apply(0, 1, 0, 0, 3, 0, 0, 3'b001, 1, 3);
    idle();

    // WAW saturation on R5.
    repeat (3) apply(0, 1, 1, 5, 0, 0, 0, 3'b000, 0, 0);
    apply(0, 1, 1, 5, 0, 0, 0, 3'b000, 0, 0);
    apply(0, 1, 1, 5, 0, 0, 0, 3'b000, 1, 5);
    apply(0, 1, 1, 5, 0, 0, 0, 3'b000, 0, 0);
    apply(1, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0);

    // Simultaneous inc/dec.
    apply(0, 1, 1, 7, 0, 0, 0, 3'b000, 0, 0);
    apply(0, 1, 1, 7, 0, 0, 0, 3'b000, 1, 7);
    apply(0, 1, 1, 2, 0, 0, 0, 3'b000, 1, 7);
    idle();

    // Flush with pending R1/R4/R9 and a concurrent accepted write.
    apply(0, 1, 1, 1, 0, 0, 0, 3'b000, 0, 0);
    apply(0, 1, 1, 4, 0, 0, 0, 3'b000, 0, 0);
    apply(0, 1, 1, 9, 0, 0, 0, 3'b000, 0, 0);
    apply(1, 1, 1, 10, 0, 0, 0, 3'b000, 0, 0);
    idle();

    // Unused sources do not stall.
    apply(0, 1, 1, 6, 0, 0, 0, 3'b000, 0, 0);
    apply(0, 1, 0, 0, 0, 6, 0, 3'b000, 0, 0);
    apply(0, 1, 0, 0, 0, 6, 0, 3'b010, 0, 0);
    apply(1, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0);

    // Randomized traffic, pointers biased to a small set for frequent hazards.
    for (int n = 0; n < 800; n++) begin
      apply($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
            int'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
            $urandom_range(0, 2) == 0, int'($urandom_range(0, 5)));
    end
    apply(1, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0);
    drain();

    // Underflow, flush keeps sb_error, async reset clears it.
    reset_n = 1'b0;
    model_reset();
    #1;
    reset_n = 1'b1;
    apply(0, 0, 0, 0, 0, 0, 0, 3'b000, 1, 12);
    apply(1, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0);
    idle();
    idle();
    drain();
    chk("err_before_reset", int'(sbi.sb_error), 1);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_err", int'(sbi.sb_error), 0);
    chk("async_reset_busy", int'(sbi.busy_mask), 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    apply(0, 1, 1, 8, 0, 0, 0, 3'b000, 0, 0);
    apply(0, 1, 0, 0, 0, 0, 8, 3'b100, 0, 0);
    idle();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rf_scoreboard.md
RF_SCOREBOARD -- requirements
Module: rf_scoreboard

Interface
REQ-001 SHALL have parameters: REG_COUNT, default 16, number of architectural registers; CNT_W, default 2, width of the per-register in-flight counter.
REQ-002 SHALL have ports: clk, input, 1, the single clock, all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port flush, input, 1, which discards all in-flight write tracking.
REQ-005 SHALL have port issue_valid, input, 1, marking an instruction at FD requesting issue.
REQ-006 SHALL have port issue_writes, input, 1, indicating the FD instruction writes a destination register (F1/F2 class).
REQ-007 SHALL have port issue_dst, input, 4, the FD destination register pointer.
REQ-008 SHALL have ports issue_src_0, issue_src_1 and issue_src_2, inputs, 4 each, the FD source register pointers.
REQ-009 SHALL have port issue_src_used, input, 3, where bit k qualifies issue_src_k.
REQ-010 SHALL have ports wb_valid, input, 1, and wb_dst, input, 4, for the MW-stage writeback of an F1/F2 result.
REQ-011 SHALL have port issue_accept, output, 1, equal to issue_valid & ~stall.
REQ-012 SHALL have port stall, output, 1, the hold request to FD.
REQ-013 SHALL have port busy_mask, output, REG_COUNT, where bit i = (count[i] != 0).
REQ-014 SHALL have port inflight_total, output, 6, the sum of all counters.
REQ-015 SHALL have port sb_error, output, 1, a sticky underflow flag.

Function
REQ-016 SHALL hold one CNT_W-bit counter count[i] per register.
REQ-017 SHALL define hit_k = issue_src_used[k] & (count[issue_src_k] != 0) & ~(wb_valid & wb_dst == issue_src_k & count[issue_src_k] == 1); RF bypass covers the last pending write.
REQ-018 SHALL drive stall = issue_valid & (hit_0 | hit_1 | hit_2 | (issue_writes & count[issue_dst] == max))), where max = 2^CNT_W-1.
REQ-019 SHALL keep stall combinational from current state and inputs, with zero-cycle latency.
REQ-020 SHALL define inc = issue_accept & issue_writes, applied to issue_dst.
REQ-021 SHALL define dec = wb_valid & count[wb_dst] != 0, applied to wb_dst.
REQ-022 SHALL update on each edge: inc only gives +1; dec only gives -1; inc and dec on the same register leaves it unchanged; inc and dec on different registers applies each to its own register.
REQ-023 SHALL make a counter at max unable to wrap, because issue is stalled at max.
REQ-024 SHALL, when wb_valid arrives on a register with count 0, leave the counter at 0 and set sb_error; sb_error stays set until reset.
REQ-025 SHALL give flush priority: all counters go to 0 at the next edge, ignoring inc and dec in that cycle.
REQ-026 SHALL still evaluate stall and issue_accept normally in a flush cycle.
REQ-027 SHALL not clear sb_error on flush.
REQ-028 SHALL produce busy_mask and inflight_total combinationally from the counters.
REQ-029 SHALL apply no special case to register 0; R0 initialisation bypasses the scoreboard.

Reset
REQ-030 SHALL asynchronously force, on reset_n low: all counters to 0, sb_error to 0, busy_mask to 0, inflight_total to 0, stall to 0 when issue_valid is 0.
REQ-031 SHALL resume tracking from empty at the first edge after reset_n deasserts, discarding writes in flight when reset occurred mid-operation.

Structure
REQ-032 SHALL place REG_COUNT, REG_PTR width (4), CNT_W and the count-max constant in the shared core definitions package.
REQ-033 SHALL instantiate one sub-module, sb_counter, per register, with inputs inc, dec, flush and outputs count and nonzero.
REQ-034 SHALL implement the stall/hit logic and the sticky error flag in rf_scoreboard.

Verification
REQ-035 SHALL cover RAW stall: issue write R3 (accept); next cycle issue src_0=R3 with used=001 -> stall=1, accept=0 until wb_valid wb_dst=3; that wb cycle itself -> stall=0, accept=1.
REQ-036 SHALL cover WAW saturation: accept three writes to R5 -> count[5]=3, busy_mask=0x0020, inflight_total=3; fourth write to R5 -> stall=1 until one wb to R5.
REQ-037 SHALL cover simultaneous events: count[7]=1, issue write R7 plus wb R7 in the same cycle -> count[7] stays 1; issue write R2 plus wb R7 -> count[2]=1, count[7]=0.
REQ-038 SHALL cover flush: pending R1, R4, R9 -> flush pulse -> next cycle busy_mask=0, inflight_total=0; a concurrent accepted write in the flush cycle is not recorded.
REQ-039 SHALL cover underflow: wb_valid to R12 with count 0 -> sb_error=1, counter stays 0; flush -> sb_error stays 1; reset_n low -> sb_error=0 asynchronously, without waiting for clk.
REQ-040 SHALL cover unused sources: pending R6 and src_1=R6 with used=000 -> stall=0.
